// File: rtl/omsp_bcd_pkg.sv
// Shared constants, FSM state type and digit helper for the digit-serial BCD adder.
package omsp_bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_ADJ     = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    function automatic logic bcd_digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/omsp_bcd_digit_add.sv
// Combinational single-digit decimal add step, with optional nine's-complement of b.
// The complement path is built only when OMSP_BCD_SUB_EN is defined.
module omsp_bcd_digit_add
    import omsp_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   c,
    input  logic                   sub,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   cout
);

    logic [BCD_DIGIT_W-1:0] b_eff;
    logic [BCD_DIGIT_W:0]   sum;

`ifdef OMSP_BCD_SUB_EN
    // 4-bit wraparound of 9 - b yields (9 - b) mod 16, also for invalid digits.
    assign b_eff = sub ? (BCD_MAX - b) : b;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
`endif

    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{BCD_DIGIT_W{1'b0}}, c};
    assign cout  = sum > {1'b0, BCD_MAX};
    assign digit = cout ? (sum[BCD_DIGIT_W-1:0] + BCD_ADJ) : sum[BCD_DIGIT_W-1:0];

endmodule

// File: rtl/omsp_bcd_seq_adder.sv
// Multi-digit packed-BCD adder/subtractor processing one digit per clock, LSD first.
// Subtraction is available only when OMSP_BCD_SUB_EN is defined; otherwise op_sub is ignored.
module omsp_bcd_seq_adder
    import omsp_bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                        mclk,
    input  logic                        puc_rst,
    input  logic                        start,
    input  logic [4*DIGITS-1:0]         op_a,
    input  logic [4*DIGITS-1:0]         op_b,
    input  logic                        carry_in,
    input  logic                        op_sub,
    output logic                        busy,
    output logic                        done,
    output logic [4*DIGITS-1:0]         result,
    output logic                        flag_c,
    output logic                        flag_z,
    output logic                        flag_n,
    output logic                        err
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    bcd_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q;

    logic [W-1:0] a_sr, b_sr, res_sr, res_next;
    logic         carry_q, sub_q;
    logic         accept, last_digit;

    logic [BCD_DIGIT_W-1:0] digit;
    logic                   cout;

    function automatic logic any_invalid(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad |= bcd_digit_invalid(v[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        return bad;
    endfunction

    assign accept     = (state_q == IDLE) && start;
    assign last_digit = (state_q == RUN) && (idx_q == LAST_IDX);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);

    // New digit enters at the top; after DIGITS shifts the LSD sits at bit 0.
    assign res_next = W'({digit, res_sr} >> BCD_DIGIT_W);

    omsp_bcd_digit_add u_digit_add (
        .a     (a_sr[BCD_DIGIT_W-1:0]),
        .b     (b_sr[BCD_DIGIT_W-1:0]),
        .c     (carry_q),
        .sub   (sub_q),
        .digit (digit),
        .cout  (cout)
    );

    // NOTE: every always_ff uses non-blocking assignments so all registers see
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            result  <= '0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q <= '0;
                err   <= any_invalid(op_a) | any_invalid(op_b);
            end else if (state_q == RUN && !last_digit) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (last_digit) begin
                result <= res_next;
                flag_c <= cout;
                flag_z <= (res_next == '0);
                flag_n <= res_next[W-1];
            end
        end
    end

    // NOTE: the working shift registers carry no reset; they are always loaded
    // on accept before being read, and only the visible outputs must clear.
    always_ff @(posedge mclk) begin
        if (accept) begin
            a_sr    <= op_a;
            b_sr    <= op_b;
            carry_q <= carry_in;
        end else if (state_q == RUN) begin
            a_sr    <= a_sr >> BCD_DIGIT_W;
            b_sr    <= b_sr >> BCD_DIGIT_W;
            carry_q <= cout;
            res_sr  <= res_next;
        end
    end

`ifdef OMSP_BCD_SUB_EN
    always_ff @(posedge mclk) begin
        if (accept)
            sub_q <= op_sub;
    end
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign sub_q         = 1'b0;
`endif

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_omsp_bcd_seq_adder.sv
// Directed, table-driven bench for omsp_bcd_seq_adder (DIGITS=4), plus hand-written
// sequences for start-while-busy and mid-operation reset.
`timescale 1ns/1ps
module tb_omsp_bcd_seq_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int NVEC   = 11;

    logic         mclk = 1'b0;
    logic         puc_rst, start, carry_in, op_sub;
    logic [W-1:0] op_a, op_b, result;
    logic         busy, done, flag_c, flag_z, flag_n, err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 mclk = ~mclk;

    omsp_bcd_seq_adder #(.DIGITS(DIGITS)) dut (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .carry_in (carry_in),
        .op_sub   (op_sub),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flag_c   (flag_c),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .err      (err)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         n;
        logic         e;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Launch one operation; returns negedges from accept until done (5 expected).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          output int cycles, output logic seen);
        @(negedge mclk);
        op_a = a; op_b = b; carry_in = cin; op_sub = sub; start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
        op_a = ~a; op_b = ~b; carry_in = ~cin; op_sub = ~sub;
        cycles = 1;
        check("busy_after_accept", W'(busy), W'(1));
        while (!done && cycles < 20) begin
            @(negedge mclk);
            cycles++;
        end
        seen = done;
    endtask

    task automatic check_outputs(input string tag, input logic [W-1:0] res,
                                 input logic c, input logic z, input logic n, input logic e);
        check({tag, "_result"}, result, res);
        check({tag, "_c"}, W'(flag_c), W'(c));
        check({tag, "_z"}, W'(flag_z), W'(z));
        check({tag, "_n"}, W'(flag_n), W'(n));
        check({tag, "_err"}, W'(err), W'(e));
    endtask

    initial begin
        int   cycles;
        logic seen;
        int   done_cnt;

        vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{16'h000A, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'h4999, 16'h5000, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{16'h1234, 16'h0F00, 1'b0, 1'b0, 16'h2734, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef OMSP_BCD_SUB_EN
        vecs[8]  = '{16'h5000, 16'h0001, 1'b1, 1'b1, 16'h4999, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0998, 1'b1, 1'b0, 1'b0, 1'b0};
`else
        vecs[8]  = '{16'h5000, 16'h0001, 1'b1, 1'b1, 16'h5002, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

        puc_rst = 1'b1; start = 1'b0; carry_in = 1'b0; op_sub = 1'b0;
        op_a = '0; op_b = '0;
        #12;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check_outputs("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge mclk);
        puc_rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, cycles, seen);
            check({tag, "_done_seen"}, W'(seen), W'(1));
            check({tag, "_latency"}, W'(cycles), W'(5));
            check({tag, "_busy_at_done"}, W'(busy), W'(0));
            check_outputs(tag, vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].e);
            @(negedge mclk);
            check({tag, "_done_pulse"}, W'(done), W'(0));
            check({tag, "_hold_result"}, result, vecs[i].res);
        end

        // start pulsed during RUN and during DONE must be ignored.
        done_cnt = 0;
        @(negedge mclk);
        op_a = 16'h1234; op_b = 16'h5678; carry_in = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
        cycles = 1;
        @(negedge mclk);
        cycles++;
        op_a = 16'h9999; op_b = 16'h9999; carry_in = 1'b1; start = 1'b1;
        @(negedge mclk);
        cycles++;
        start = 1'b0;
        while (!done && cycles < 20) begin
            @(negedge mclk);
            cycles++;
        end
        if (done) done_cnt++;
        check("busy_start_latency", W'(cycles), W'(5));
        check_outputs("busy_start", 16'h6912, 1'b0, 1'b0, 1'b0, 1'b0);
        op_a = 16'h0005; op_b = 16'h0005; start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
        check("done_start_busy", W'(busy), W'(0));
        for (int k = 0; k < 10; k++) begin
            if (done) done_cnt++;
            @(negedge mclk);
        end
        check("busy_start_done_count", W'(done_cnt), W'(1));
        check("busy_start_hold", result, 16'h6912);

        // Mid-operation reset with non-zero outputs beforehand.
        run_op(16'h9999, 16'h9999, 1'b1, 1'b0, cycles, seen);
        check_outputs("pre_rst", 16'h9999, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge mclk);
        op_a = 16'h000A; op_b = 16'h0000; carry_in = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
        check("mid_err_set", W'(err), W'(1));
        @(negedge mclk);
        #2 puc_rst = 1'b1;
        #1;
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_done", W'(done), W'(0));
        check_outputs("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge mclk);
        puc_rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (done || busy) done_cnt++;
            @(negedge mclk);
        end
        check("post_rst_idle", W'(done_cnt), W'(0));
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, cycles, seen);
        check("post_rst_done_seen", W'(seen), W'(1));
        check("post_rst_latency", W'(cycles), W'(5));
        check_outputs("post_rst", 16'h6912, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
